// File: rtl/polar_bp_pkg.sv
// Shared types and defaults for the 8-point polar BP iteration scheduler.
`ifndef POLAR_LANE
`define POLAR_LANE(v, i, w) v[(i)*(w) +: (w)]
`endif

package polar_bp_pkg;
  localparam int          N_DEF      = 8;
  localparam int          SIZE_DEF   = 20;
  localparam logic [7:0]  FROZEN_DEF = 8'h17;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LAUNCH, S_WAIT_LO, S_WAIT_HI, S_CHECK, S_OUT
  } state_t;
endpackage

// File: rtl/polar_hd_slicer.sv
// Hard-decision slicer: sign bit of each LLR lane, frozen positions forced to 0.
`ifndef POLAR_LANE
`define POLAR_LANE(v, i, w) v[(i)*(w) +: (w)]
`endif

module polar_hd_slicer #(
  parameter int N    = 8,
  parameter int SIZE = 20
) (
  input  logic [N*SIZE-1:0] i_llr,
  input  logic [N-1:0]      i_frozen,
  output logic [N-1:0]      o_hd
);
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [SIZE-1:0] w_lane;
    assign w_lane  = `POLAR_LANE(i_llr, g, SIZE);
    assign o_hd[g] = w_lane[SIZE-1] & ~i_frozen[g];
  end
endmodule

// File: rtl/polar_bp_sched.sv
// Frame intake, BP iteration launch/convergence control and result handoff
// for the 8-point polar BP decoder core.
module polar_bp_sched
  import polar_bp_pkg::*;
#(
  parameter int             N           = N_DEF,
  parameter int             SIZE        = SIZE_DEF,
  parameter int             MAX_ITER    = 8,
  parameter int             MIN_ITER    = 2,
  parameter bit             ES_EN       = 1'b1,
  parameter logic [N-1:0]   FROZEN_MASK = FROZEN_DEF,
  parameter int             TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*SIZE-1:0] in_llr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_bits,
  output logic [3:0]        out_iters,
  output logic              out_early,
  output logic              out_timeout,
  output logic              dec_en,
  input  logic              dec_done,
  output logic [N*SIZE-1:0] dec_llr_in,
  input  logic [N*SIZE-1:0] dec_llr_out
);
  localparam int         WDW  = $clog2(TIMEOUT + 1);
  localparam logic [3:0] MAXI = 4'(MAX_ITER);
  localparam logic [3:0] MINI = 4'(MIN_ITER);

  state_t              r_state, w_next;
  logic                r_alive;
  logic [N*SIZE-1:0]   r_llr;
  logic [3:0]          r_cnt;
  logic [N-1:0]        r_prev, r_bits;
  logic                r_early, r_to;
  logic [WDW-1:0]      r_wd;
  logic [N-1:0]        w_hd;
  logic                w_wait, w_wd_exp, w_es;

  polar_hd_slicer #(.N(N), .SIZE(SIZE)) u_slicer (
    .i_llr    (dec_llr_out),
    .i_frozen (FROZEN_MASK),
    .o_hd     (w_hd)
  );

  assign w_wait   = (r_state == S_SYNC) || (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
  assign w_wd_exp = w_wait && (r_wd == WDW'(TIMEOUT - 1));
  assign w_es     = ES_EN && (r_cnt >= MINI) && (w_hd == r_prev);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (in_valid && r_alive) w_next = S_SYNC;
      S_SYNC:    if (dec_done) w_next = S_LAUNCH;  else if (w_wd_exp) w_next = S_OUT;
      S_LAUNCH:  w_next = S_WAIT_LO;
      // a done level still high from the previous pass is not a completion
      S_WAIT_LO: if (!dec_done) w_next = S_WAIT_HI; else if (w_wd_exp) w_next = S_OUT;
      S_WAIT_HI: if (dec_done) w_next = S_CHECK;   else if (w_wd_exp) w_next = S_OUT;
      S_CHECK:   w_next = (w_es || r_cnt == MAXI) ? S_OUT : S_LAUNCH;
      S_OUT:     if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_alive <= 1'b0;
      r_llr   <= '0;
      r_cnt   <= '0;
      r_prev  <= '0;
      r_bits  <= '0;
      r_early <= 1'b0;
      r_to    <= 1'b0;
      r_wd    <= '0;
    end else begin
      r_state <= w_next;
      r_alive <= 1'b1;
      if (w_next != r_state) r_wd <= '0;
      else if (w_wait)       r_wd <= r_wd + 1'b1;

      case (r_state)
        S_IDLE: if (in_valid && r_alive) begin
          r_llr   <= in_llr;
          r_bits  <= '0;
          r_early <= 1'b0;
          r_to    <= 1'b0;
        end
        S_WAIT_HI: if (dec_done) r_cnt <= r_cnt + 1'b1;
        S_CHECK: if (w_next == S_OUT) begin
          r_bits  <= w_hd;
          r_early <= w_es;
        end else begin
          r_prev  <= w_hd;
        end
        S_OUT: if (out_ready) begin
          r_cnt  <= '0;
          r_prev <= '0;
        end
        default: ;
      endcase

      if (w_wd_exp && w_next == S_OUT) begin
        r_to   <= 1'b1;
        r_bits <= '0;
      end
    end
  end

  assign in_ready    = r_alive && (r_state == S_IDLE);
  assign out_valid   = (r_state == S_OUT);
  assign out_bits    = r_bits;
  assign out_iters   = r_cnt;
  assign out_early   = r_early;
  assign out_timeout = r_to;
  assign dec_en      = (r_state == S_LAUNCH);
  assign dec_llr_in  = r_llr;
endmodule

// File: tb/tb_polar_bp_sched.sv
// Directed bench for polar_bp_sched with a behavioural stub of the BP core.
module tb_polar_bp_sched;
  localparam int N = 8, SIZE = 20, W = N*SIZE;
  localparam logic [7:0]      ES_MASK = 8'hE8;
  localparam logic [SIZE-1:0] POS = 20'h00100, NEG = 20'hFFF00;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic out_early, out_timeout, dec_en, dec_done;
  logic [W-1:0] in_llr, dec_llr_in, dec_llr_out;
  logic [N-1:0] out_bits;
  logic [3:0]   out_iters;

  int total = 0, bad = 0;

  logic [1:0] mode;
  logic       s_hang;
  logic [4:0] s_busy;
  logic [3:0] s_iter;

  polar_bp_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_llr(in_llr), .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .out_iters(out_iters), .out_early(out_early),
    .out_timeout(out_timeout), .dec_en(dec_en), .dec_done(dec_done),
    .dec_llr_in(dec_llr_in), .dec_llr_out(dec_llr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // core stub: done drops on dec_en and returns after 16 cycles; optional hang from the 3rd pass
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_busy <= 5'd16; dec_done <= 1'b0; s_iter <= 4'd0;
    end else if (in_valid && in_ready) begin
      s_iter <= 4'd0;
    end else if (dec_en) begin
      s_busy <= 5'd16; dec_done <= 1'b0; s_iter <= s_iter + 4'd1;
    end else begin
      if (s_busy != 5'd0) s_busy <= s_busy - 5'd1;
      dec_done <= (s_busy <= 5'd1) && !(s_hang && s_iter >= 4'd3);
    end
  end

  // mode 0: lane 3 negative on odd passes; 1: lanes 3,5,6,7 negative; 2: all negative; 3: all positive
  always_comb begin
    dec_llr_out = '0;
    for (int i = 0; i < N; i++) begin
      logic neg;
      case (mode)
        2'd0:    neg = (i == 3) && s_iter[0];
        2'd1:    neg = ES_MASK[i];
        2'd2:    neg = 1'b1;
        default: neg = 1'b0;
      endcase
      dec_llr_out[i*SIZE +: SIZE] = neg ? NEG : POS;
    end
  end

  typedef struct {
    logic [1:0]   mode;
    logic         hang;
    logic [W-1:0] llr;
    logic [7:0]   bits;
    logic [3:0]   iters;
    logic         early;
    logic         to;
    logic [3:0]   pulses;
    logic         chk_lat;
  } rec_t;

  rec_t vec[5];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic accept(input logic [W-1:0] llr);
    int cyc = 0;
    while (!in_ready && cyc < 200) begin @(negedge clk); cyc++; end
    chk("in_ready_before_frame", in_ready, 1);
    in_llr = llr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_llr = {8{20'hABCDE}};
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic do_frame(input rec_t r);
    int cyc;
    mode = r.mode; s_hang = r.hang; out_ready = 1'b1;
    accept(r.llr);
    wait_out(cyc);
    if (r.chk_lat) begin
      total++;
      if (cyc < 153 || cyc > 155) begin
        bad++;
        $display("FAIL latency got=%0d exp=153..155", cyc);
      end
    end
    chk("out_bits",    out_bits,    r.bits);
    chk("out_iters",   out_iters,   r.iters);
    chk("out_early",   out_early,   r.early);
    chk("out_timeout", out_timeout, r.to);
    chk("dec_en_pulses", s_iter,    r.pulses);
    chk("llr_hold",    dec_llr_in,  r.llr);
    @(posedge clk); #1;
    chk("xfer_valid_drop", out_valid, 0);
    chk("xfer_in_ready",   in_ready,  1);
    s_hang = 1'b0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_llr = '0; out_ready = 1'b0;
    mode = 2'd3; s_hang = 1'b0;

    vec[0] = '{2'd0, 1'b0, {8{POS}},         8'h00, 4'd8, 1'b0, 1'b0, 4'd8, 1'b1};
    vec[1] = '{2'd1, 1'b0, {8{20'h12345}},   8'hE8, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0};
    vec[2] = '{2'd2, 1'b0, {8{20'h80001}},   8'hE8, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0};
    vec[3] = '{2'd0, 1'b1, {8{20'h0F0F0}},   8'h00, 4'd2, 1'b0, 1'b1, 4'd3, 1'b0};
    vec[4] = '{2'd3, 1'b0, {4{40'h00001_FFFFF}}, 8'h00, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  in_ready,   0);
    chk("rst_out_valid", out_valid,  0);
    chk("rst_dec_en",    dec_en,     0);
    chk("rst_out_iters", out_iters,  0);
    chk("rst_out_bits",  out_bits,   0);
    chk("rst_llr_hold",  dec_llr_in, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 5; i++) do_frame(vec[i]);

    // backpressure: result must hold while the sink stalls
    mode = 2'd1; out_ready = 1'b0;
    accept({8{POS}});
    wait_out(cyc);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid",    out_valid, 1);
      chk("bp_bits",     out_bits,  8'hE8);
      chk("bp_iters",    out_iters, 4'd2);
      chk("bp_in_ready", in_ready,  0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_valid_until_edge", out_valid, 1);
    @(posedge clk); #1;
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_in_ready",   in_ready,  1);

    // reset during WAIT_HI of iteration 4
    mode = 2'd0;
    accept({8{POS}});
    cyc = 0;
    while (s_iter != 4'd4 && cyc < 500) begin @(negedge clk); cyc++; end
    chk("mr_reach_iter4", s_iter, 4'd4);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid",   out_valid,   0);
    chk("mr_in_ready",    in_ready,    0);
    chk("mr_dec_en",      dec_en,      0);
    chk("mr_out_iters",   out_iters,   0);
    chk("mr_out_bits",    out_bits,    0);
    chk("mr_out_early",   out_early,   0);
    chk("mr_out_timeout", out_timeout, 0);
    chk("mr_llr_hold",    dec_llr_in,  0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mr_in_ready_at_release", in_ready, 0);
    @(posedge clk); #1;
    chk("mr_in_ready_after", in_ready,  1);
    chk("mr_no_stale_valid", out_valid, 0);
    // frame accepted at once must wait out the core's post-reset pass in SYNC
    do_frame(vec[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
